// File: rtl/salsa_pkg.sv
// Shared types and constants for the Salsa20 stream XOR front end.
package salsa_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_WAIT, ST_CAPTURE, ST_STREAM
  } state_e;

  localparam int SALSA_LOAD_WORDS  = 12;
  localparam int SALSA_BLOCK_BYTES = 64;

  localparam logic [3:0] CFG_KEY0   = 4'd0;
  localparam logic [3:0] CFG_NONCE0 = 4'd8;
  localparam logic [3:0] CFG_NONCE1 = 4'd9;
  localparam logic [3:0] CFG_POS_LO = 4'd10;
  localparam logic [3:0] CFG_POS_HI = 4'd11;

  localparam logic [31:0] SALSA_SIGMA0 = 32'h6170_7865;
  localparam logic [31:0] SALSA_SIGMA1 = 32'h3320_646e;
  localparam logic [31:0] SALSA_SIGMA2 = 32'h7962_2d32;
  localparam logic [31:0] SALSA_SIGMA3 = 32'h6b20_6574;
endpackage

// File: rtl/salsa_ks_buffer.sv
// One-block keystream buffer: sequential write from the core, sequential read by the stream.
module salsa_ks_buffer
  import salsa_pkg::*;
#(
  parameter int DEPTH = SALSA_BLOCK_BYTES,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [7:0]    i_wdata,
  input  logic          i_rd,
  output logic [7:0]    o_rdata,
  output logic [AW-1:0] o_wptr,
  output logic [AW-1:0] o_rptr,
  output logic          o_full,
  output logic          o_empty
);
  logic [7:0] r_mem [DEPTH];
  logic [AW:0] r_wcnt, r_rcnt;

  assign o_full  = (r_wcnt == (AW+1)'(DEPTH));
  assign o_empty = (r_rcnt == r_wcnt);
  assign o_wptr  = r_wcnt[AW-1:0];
  assign o_rptr  = r_rcnt[AW-1:0];
  assign o_rdata = r_mem[r_rcnt[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wcnt <= '0;
      r_rcnt <= '0;
    end else if (i_clr) begin
      r_wcnt <= '0;
      r_rcnt <= '0;
    end else begin
      if (i_we && !o_full) begin
        r_mem[r_wcnt[AW-1:0]] <= i_wdata;
        r_wcnt <= r_wcnt + 1'b1;
      end
      if (i_rd && !o_empty) r_rcnt <= r_rcnt + 1'b1;
    end
  end
endmodule

// File: rtl/salsa_stream_xor.sv
// Drives salsa_hash load bursts, buffers each 64-byte keystream block and XORs it onto a byte stream.
// Optional SALSA_POS_WRAP_ERR_EN: flag an error instead of wrapping the 64-bit block position.
module salsa_stream_xor
  import salsa_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_core_rst,
  input  logic        i_cfg_we,
  input  logic [3:0]  i_cfg_addr,
  input  logic [31:0] i_cfg_data,
  input  logic        i_enable,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [7:0]  i_in_data,
  output logic        o_out_valid,
  output logic [7:0]  o_out_data,
  output logic        o_core_start,
  output logic [31:0] o_core_data,
  input  logic        i_core_ready,
  input  logic        i_core_writes,
  input  logic [7:0]  i_core_byte,
  output logic [63:0] o_pos_out,
  output logic        o_busy,
  output logic        o_error
);
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [5:0] LAST = 6'(SALSA_BLOCK_BYTES - 1);

  state_e              r_state;
  logic [7:0][31:0]    r_key;
  logic [1:0][31:0]    r_nonce;
  logic [63:0]         r_pos;
  logic [3:0]          r_k;
  logic [WW-1:0]       r_wait;
  logic                r_error, r_out_valid, r_core_rst;
  logic [7:0]          r_out_data;

  logic [7:0]  w_rdata;
  logic [5:0]  w_wptr, w_rptr;
  logic        w_full, w_empty, w_hs, w_cap_we, w_can_load, w_last_rd, w_clr;
  logic [31:0] w_load_word;

  assign o_in_ready  = (r_state == ST_STREAM) && !w_empty;
  assign w_hs        = i_in_valid && o_in_ready;
  assign w_cap_we    = i_core_writes && !w_full && (r_state == ST_WAIT || r_state == ST_CAPTURE);
  assign w_can_load  = i_enable && i_core_ready && !r_error;
  assign w_last_rd   = w_hs && (w_rptr == LAST);
  // Pointers restart whenever a new fetch begins or a partial capture is abandoned.
  assign w_clr       = ((r_state == ST_IDLE) && w_can_load) || (w_last_rd && w_can_load) ||
                       ((r_state == ST_CAPTURE) && !i_core_writes);

  always_comb begin
    w_load_word = r_pos[63:32];
    case (r_k)
      4'd8:    w_load_word = r_nonce[0];
      4'd9:    w_load_word = r_nonce[1];
      4'd10:   w_load_word = r_pos[31:0];
      4'd11:   w_load_word = r_pos[63:32];
      default: if (!r_k[3]) w_load_word = r_key[r_k[2:0]];
    endcase
  end

  assign o_core_start = (r_state == ST_LOAD) && (r_k == 4'd0);
  assign o_core_data  = (r_state == ST_LOAD) ? w_load_word : '0;
  assign o_core_rst   = r_core_rst;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_pos_out    = r_pos;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_error      = r_error;

  salsa_ks_buffer u_buf (
    .i_clk(i_clk), .i_rst_n(i_reset), .i_clr(w_clr),
    .i_we(w_cap_we), .i_wdata(i_core_byte), .i_rd(w_hs),
    .o_rdata(w_rdata), .o_wptr(w_wptr), .o_rptr(w_rptr),
    .o_full(w_full), .o_empty(w_empty)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_key       <= '0;
      r_nonce     <= '0;
      r_pos       <= '0;
      r_k         <= '0;
      r_wait      <= '0;
      r_error     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_core_rst  <= 1'b1;
    end else begin
      r_core_rst  <= 1'b0;
      r_out_valid <= w_hs;
      if (w_hs) r_out_data <= i_in_data ^ w_rdata;
      case (r_state)
        ST_IDLE: begin
          if (i_cfg_we) begin
            if (!i_cfg_addr[3]) r_key[i_cfg_addr[2:0]] <= i_cfg_data;
            else case (i_cfg_addr)
              CFG_NONCE0: r_nonce[0]    <= i_cfg_data;
              CFG_NONCE1: r_nonce[1]    <= i_cfg_data;
              CFG_POS_LO: r_pos[31:0]   <= i_cfg_data;
              CFG_POS_HI: r_pos[63:32]  <= i_cfg_data;
              default: ;
            endcase
          end
          if (w_can_load) begin
            r_state <= ST_LOAD;
            r_k     <= '0;
          end
        end
        ST_LOAD: begin
          r_k <= r_k + 4'd1;
          if (r_k == 4'(SALSA_LOAD_WORDS - 1)) begin
            r_state <= ST_WAIT;
            r_wait  <= '0;
          end
        end
        ST_WAIT: begin
          if (i_core_writes) r_state <= ST_CAPTURE;
          else if (r_wait == WW'(WAIT_LIMIT - 1)) begin
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end else r_wait <= r_wait + 1'b1;
        end
        ST_CAPTURE: begin
          if (!i_core_writes) begin
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_wptr == LAST) begin
            r_state <= ST_STREAM;
`ifdef SALSA_POS_WRAP_ERR_EN
            if (&r_pos) r_error <= 1'b1;
            else r_pos <= r_pos + 64'd1;
`else
            r_pos <= r_pos + 64'd1;
`endif
          end
        end
        ST_STREAM: begin
          if (w_last_rd) begin
            r_state <= w_can_load ? ST_LOAD : ST_IDLE;
            r_k     <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_salsa_stream_xor.sv
// Scoreboard bench for salsa_stream_xor with a behavioural Salsa20 core model.
module tb_salsa_stream_xor;
  import salsa_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0;
  logic core_rst, cfg_we, enable, in_valid, in_ready, out_valid;
  logic core_start, core_ready, core_writes, busy, error;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_data, core_data;
  logic [7:0]  in_data, out_data, core_byte;
  logic [63:0] pos_out;

  always #5 clk = ~clk;

  salsa_stream_xor #(.WAIT_LIMIT(255)) dut (
    .i_clk(clk), .i_reset(rst_n), .o_core_rst(core_rst),
    .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
    .i_enable(enable), .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .o_out_data(out_data),
    .o_core_start(core_start), .o_core_data(core_data),
    .i_core_ready(core_ready), .i_core_writes(core_writes), .i_core_byte(core_byte),
    .o_pos_out(pos_out), .o_busy(busy), .o_error(error)
  );

  int checks = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0][31:0] g_key;
  logic [1:0][31:0] g_nonce;
  int waits [0:255];

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [15:0][31:0] qr(input logic [15:0][31:0] x, input int a, b, c, d);
    x[b] ^= rotl(x[a] + x[d], 7);
    x[c] ^= rotl(x[b] + x[a], 9);
    x[d] ^= rotl(x[c] + x[b], 13);
    x[a] ^= rotl(x[d] + x[c], 18);
    return x;
  endfunction

  // w: key0..7, nonce0, nonce1, pos_lo, pos_hi -> 64 keystream bytes, byte i at [8i+:8]
  function automatic logic [511:0] salsa_block(input logic [11:0][31:0] w);
    logic [15:0][31:0] x, s;
    logic [511:0] o;
    x[0] = SALSA_SIGMA0; x[5] = SALSA_SIGMA1; x[10] = SALSA_SIGMA2; x[15] = SALSA_SIGMA3;
    for (int i = 0; i < 4; i++) begin x[1+i] = w[i]; x[11+i] = w[4+i]; end
    x[6] = w[8]; x[7] = w[9]; x[8] = w[10]; x[9] = w[11];
    s = x;
    for (int r = 0; r < 10; r++) begin
      x = qr(x, 0, 4, 8, 12);  x = qr(x, 5, 9, 13, 1);
      x = qr(x, 10, 14, 2, 6); x = qr(x, 15, 3, 7, 11);
      x = qr(x, 0, 1, 2, 3);   x = qr(x, 5, 6, 7, 4);
      x = qr(x, 10, 11, 8, 9); x = qr(x, 15, 12, 13, 14);
    end
    for (int j = 0; j < 16; j++) o[32*j +: 32] = x[j] + s[j];
    return o;
  endfunction

  function automatic logic [7:0] ks_byte(input logic [63:0] base, input int n);
    logic [11:0][31:0] w;
    logic [63:0] p;
    logic [511:0] b;
    p = base + 64'(n / 64);
    for (int i = 0; i < 8; i++) w[i] = g_key[i];
    w[8] = g_nonce[0]; w[9] = g_nonce[1]; w[10] = p[31:0]; w[11] = p[63:32];
    b = salsa_block(w);
    return b[8*(n % 64) +: 8];
  endfunction

  // Core model: latches the 12 words after core_start, first byte 23 cycles after start.
  logic m_busy = 1'b0, m_nowrite = 1'b0;
  int m_cnt = 0;
  logic [11:0][31:0] m_w;
  logic [511:0] m_ks = '0;
  always @(posedge clk) begin
    if (core_rst) begin
      m_busy <= 1'b0; m_cnt <= 0;
    end else if (!m_busy) begin
      if (core_start) begin m_busy <= 1'b1; m_cnt <= 1; m_w[0] <= core_data; end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt < 12) m_w[m_cnt] <= core_data;
      if (m_cnt == 12) m_ks <= salsa_block(m_w);
      if (m_cnt == 86) m_busy <= 1'b0;
    end
  end
  assign core_ready  = !m_busy;
  assign core_writes = m_busy && !m_nowrite && (m_cnt >= 23) && (m_cnt <= 86);
  always_comb begin
    core_byte = 8'h00;
    if (core_writes) core_byte = m_ks[8*(m_cnt-23) +: 8];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct { logic [7:0] d; int c; } exp_t;
  exp_t sbq[$];

  // Monitor: every output byte must match the oldest expectation and its cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_out: got %h with nothing expected", out_data);
      end else begin
        e = sbq.pop_front();
        chk("out_data", {56'd0, out_data}, {56'd0, e.d});
        chk("out_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  int start_cnt = 0, ld_idx = 12;
  logic [31:0] ld_words [12];
  initial forever begin
    @(negedge clk);
    if (core_start === 1'b1) begin start_cnt++; ld_idx = 0; end
    if (ld_idx < 12) begin ld_words[ld_idx] = core_data; ld_idx++; end
  end

  task automatic cfg(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk); cfg_we = 1'b0;
  endtask

  task automatic run_stream(input int nb, input int start, input logic [63:0] base,
                            input logic [7:0] fill, input bit stall, input bit drop_en);
    int n, w;
    exp_t e;
    for (int i = 0; i < nb; i++) begin
      n = start + i;
      @(negedge clk); in_valid = 1'b1; in_data = fill; w = 0;
      while (in_ready !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
      if (in_ready !== 1'b1) begin
        checks++; fails++;
        $display("FAIL stream_timeout: byte %0d never accepted, limit 2000 cycles", n);
        in_valid = 1'b0;
        return;
      end
      e.d = fill ^ ks_byte(base, n); e.c = cyc + 1;
      sbq.push_back(e);
      waits[n] = w;
      if (i == 0 && drop_en) enable = 1'b0;
      if (stall) begin @(negedge clk); in_valid = 1'b0; end
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int w = 0;
    while (busy !== 1'b0 && w < 500) begin @(negedge clk); w++; end
    chk(nm, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int w, snap;
    cfg_we = 0; cfg_addr = 0; cfg_data = 0; enable = 0; in_valid = 0; in_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_core_rst", {63'd0, core_rst}, 64'd1);
    chk("rst_flags", {59'd0, out_valid, in_ready, busy, error, core_start}, 64'd0);
    chk("rst_pos", pos_out, 64'd0);
    chk("rst_core_data", {32'd0, core_data}, 64'd0);
    rst_n = 1'b1;
    #1 chk("core_rst_hold", {63'd0, core_rst}, 64'd1);
    @(negedge clk);
    chk("core_rst_release", {63'd0, core_rst}, 64'd0);

    for (int i = 0; i < 8; i++)
      g_key[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    g_nonce[0] = 32'h1; g_nonce[1] = 32'h0;
    for (int i = 0; i < 8; i++) cfg(4'(i), g_key[i]);
    cfg(CFG_NONCE0, g_nonce[0]); cfg(CFG_NONCE1, g_nonce[1]);
    cfg(CFG_POS_LO, 0); cfg(CFG_POS_HI, 0);
    cfg(4'd12, 32'hDEAD_BEEF);

    // single block and load burst order
    enable = 1'b1;
    run_stream(64, 0, 64'd0, 8'h00, 0, 1);
    wait_idle("blk0_idle");
    chk("blk0_pos", pos_out, 64'd1);
    chk("blk0_starts", 64'(start_cnt), 64'd1);
    for (int i = 0; i < 12; i++)
      chk($sformatf("load_word%0d", i), {32'd0, ld_words[i]},
          {32'd0, (i < 8) ? g_key[i] : (i == 8) ? 32'h1 : 32'h0});

    // multi-block from position 0
    cfg(CFG_POS_LO, 0);
    enable = 1'b1;
    run_stream(130, 0, 64'd0, 8'hFF, 0, 0);
    chk("multi_pos", pos_out, 64'd3);
    chk("refill_gap64", {63'd0, waits[64] >= 80}, 64'd1);
    chk("refill_gap128", {63'd0, waits[128] >= 80}, 64'd1);
    enable = 1'b0;
    run_stream(62, 130, 64'd0, 8'hFF, 0, 0);
    wait_idle("multi_idle");

    // input stall, block position 3
    enable = 1'b1;
    run_stream(64, 0, 64'd3, 8'hA5, 1, 1);
    wait_idle("stall_idle");
    chk("stall_pos", pos_out, 64'd4);

    // position wrap
    cfg(CFG_POS_LO, 32'hFFFF_FFFF); cfg(CFG_POS_HI, 32'hFFFF_FFFF);
    enable = 1'b1;
    run_stream(64, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h3C, 0, 1);
    wait_idle("wrap_idle");
`ifdef SALSA_POS_WRAP_ERR_EN
    chk("wrap_error", {63'd0, error}, 64'd1);
    chk("wrap_pos_hold", pos_out, 64'hFFFF_FFFF_FFFF_FFFF);
    snap = start_cnt; enable = 1'b1;
    repeat (40) @(negedge clk);
    chk("wrap_no_load", 64'(start_cnt), 64'(snap));
    enable = 1'b0;
`else
    chk("wrap_error", {63'd0, error}, 64'd0);
    chk("wrap_pos", pos_out, 64'd0);
`endif

    // reset in the middle of CAPTURE
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("reset_clears_err", {63'd0, error}, 64'd0);
    enable = 1'b1; w = 0;
    while (core_writes !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    chk("capture_reached", {63'd0, core_writes}, 64'd1);
    repeat (5) @(negedge clk);
    chk("mid_capture_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_core_rst", {63'd0, core_rst}, 64'd1);
    chk("midrst_flags", {59'd0, out_valid, in_ready, busy, error, core_start}, 64'd0);
    chk("midrst_pos", pos_out, 64'd0);
    chk("midrst_core_data", {32'd0, core_data}, 64'd0);
    enable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // core timeout: 12 load cycles then WAIT_LIMIT wait cycles
    m_nowrite = 1'b1; enable = 1'b1; w = 0;
    while (core_start !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    chk("timeout_start", {63'd0, core_start}, 64'd1);
    w = 0;
    while (error !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
    chk("timeout_cycles", 64'(w), 64'(SALSA_LOAD_WORDS + 255));
    chk("timeout_idle", {62'd0, error, busy}, 64'd2);
    snap = start_cnt;
    repeat (50) @(negedge clk);
    chk("timeout_no_restart", 64'(start_cnt), 64'(snap));
    enable = 1'b0;

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/salsa_stream_xor.md
# salsa_stream_xor

Host-side driver for the `salsa_hash` core. Holds key, nonce and a 64-bit block position, and sequences the core's 12-word load burst. It captures the core's 64-byte keystream burst into a local buffer, then XORs that keystream byte-by-byte with an incoming plaintext/ciphertext stream. The block sits between the host byte stream and the core, advancing the position so consecutive blocks form a continuous Salsa20 keystream.

## Interface
- `WAIT_LIMIT`, 255: maximum cycles in WAIT before the block flags a core timeout.
- `clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-low. Clears all state.
- `core_rst` out 1: synchronous reset to the core. High while `reset` is low and for 1 cycle after `reset` deasserts.
- `cfg_we` in 1: configuration write strobe.
- `cfg_addr` in 4: word select.
  - 0–7: key[0..7].
  - 8–9: nonce[0..1].
  - 10: pos_lo.
  - 11: pos_hi.
  - 12–15: ignored.
- `cfg_data` in 32: configuration write data.
- `enable` in 1: permits fetching of new keystream blocks.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 8: input byte stream.
- `out_valid` out 1, `out_data` out 8: XORed output byte stream. No backpressure.
- `core_start` out 1, `core_data` out 32: load burst to the core.
- `core_ready` in 1, `core_writes` in 1, `core_byte` in 8: core status and keystream bytes.
- `pos_out` out 64: position of the next block to be fetched.
- `busy` out 1: high whenever state ≠ IDLE.
- `error` out 1: sticky fault flag.

## Operation
- **Reset values:** all outputs 0 except `core_rst`=1. Key, nonce, position and buffer are 0.
- **Config writes:** accepted only in IDLE; ignored in any other state.
- **IDLE:** leave to LOAD when `enable`=1, `core_ready`=1 and `error`=0.
- **LOAD:** 12 cycles, counter k = 0..11.
  - `core_start`=1 only at k=0.
  - `core_data` = word k, in order key0..key7, nonce0, nonce1, pos_lo, pos_hi.
  - After k=11, go to WAIT. `core_data` returns to 0.
- **WAIT:** go to CAPTURE on the first cycle `core_writes`=1; that cycle's `core_byte` is byte 0.
  - A wait counter runs during WAIT.
  - If the counter reaches `WAIT_LIMIT` first: set `error`, go to IDLE.
- **CAPTURE:** store `core_byte` at wptr on every cycle `core_writes`=1, wptr 0..63.
  - On the write of byte 63: position += 1, modulo 2^64, then go to STREAM with rptr=0.
  - If `core_writes` drops before byte 63: set `error`, go to IDLE, discard the buffer.
- **STREAM:** `in_ready`=1.
  - On each handshake (`in_valid`&`in_ready`): `out_data` = `in_data` ^ buf[rptr], registered; `out_valid`=1 for exactly 1 cycle; rptr increments.
  - After rptr=63 is consumed, `in_ready` drops the next cycle. Go to LOAD if `enable`=1 and `core_ready`=1, otherwise to IDLE.
  - Clearing `enable` in STREAM does not discard the buffer; the buffer is always drained first.
- **Byte order:** keystream byte i of a block XORs with the i-th stream byte of that block.
- **Mid-operation reset:** all state is lost immediately. `core_rst` forces the core back to its own idle state.

## Timing
- `in_data` handshake at cycle t → `out_valid` at t+1. Throughput: 1 byte/cycle in STREAM.
- `core_start` cycle → first `core_writes` cycle is 23 cycles later with the core as built. `WAIT_LIMIT` must exceed this.
- Minimum refill gap is 1 + 12 + ~10 + 64 cycles. `in_ready` stays 0 throughout the gap.
- `pos_out` updates on the cycle after capture of byte 63.

## Configuration
- `SALSA_POS_WRAP_ERR_EN` defined: a block capture that would wrap position from 0xFFFF_FFFF_FFFF_FFFF to 0 instead sets `error`. The buffer is still streamed. Position holds at all-ones, and no further LOAD occurs.
- Not defined: position wraps silently to 0.

## Structure
- **Package `salsa_pkg`:**
  - state enum (IDLE, LOAD, WAIT, CAPTURE, STREAM);
  - `SALSA_LOAD_WORDS`=12 and `SALSA_BLOCK_BYTES`=64;
  - config address constants;
  - the four sigma constants, for the bench model.
- **Sub-module `salsa_ks_buffer`:** 64×8 register file with write port, wptr, rptr and a `full`/`empty` indication.

## Test plan
- **Single block:** key words 0x03020100…0x1F1E1D1C, nonce 0x1, pos 0, `enable`=1. Stream 64 bytes of 0x00 → `out_data` equals the reference Salsa20 block 0 bytes; `pos_out`=1 afterwards.
- **Load burst order:** `core_start` is high for exactly 1 cycle. `core_data` sequence is key0..key7, nonce0, nonce1, 0x0, 0x0 on 12 consecutive cycles.
- **Multi-block:** stream 130 bytes of 0xFF. Bytes 64 and 128 use blocks pos=1 and pos=2. `in_ready` is low during each refill. `pos_out` ends at 3.
- **Input stall:** `in_valid` toggles every other cycle → `out_valid` follows each handshake by 1 cycle; no keystream byte is skipped.
- **Core timeout:** core model never asserts `core_writes` → `error`=1 after `WAIT_LIMIT` cycles, state IDLE, no further `core_start`.
- **Wrap and reset:** pos_lo=pos_hi=0xFFFFFFFF, then one block.
  - With the macro: `error`=1 and `pos_out` stays all-ones.
  - Without the macro: `pos_out`=0.
  - Asserting `reset` low mid-CAPTURE → all outputs return to reset values on the same cycle.
